// File: rtl/brightness_control_pkg.sv
// Shared types and constants for the brightness control Avalon-ST Video encoder.
package brightness_control_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_CTYPE = 5'b00010,
      ST_CHEAD = 5'b00100,
      ST_VTYPE = 5'b01000,
      ST_DATA  = 5'b10000
   } state_t;

   localparam logic [3:0] TYPE_CTRL  = 4'hF;
   localparam logic [3:0] TYPE_VIDEO = 4'h0;

   // Nine header nibbles spread over COLOR_PLANES symbols per beat.
   function automatic int unsigned hdr_beats(input int unsigned planes);
      return (9 + planes - 1) / planes;
   endfunction

endpackage

// File: rtl/brightness_control_encode_if.sv
// Avalon-ST Video stream bundle: data/valid/sop/eop forward, ready backward.
interface brightness_control_encode_if #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  startofpacket;
   logic                  endofpacket;
   logic                  ready;

   modport master (output data, valid, startofpacket, endofpacket, input ready);
   modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/brightness_control_hdr_pack.sv
// Packs the latched frame dimensions into one control-packet header beat.
module brightness_control_hdr_pack #(
   parameter int DATA_WIDTH   = 24,
   parameter int COLOR_BITS   = 8,
   parameter int COLOR_PLANES = 3
) (
   input  logic [15:0]           width,
   input  logic [15:0]           height,
   input  logic [3:0]            interlaced,
   input  logic [3:0]            beat,
   output logic [DATA_WIDTH-1:0] data
);
   logic [3:0] nib [9];
   logic [7:0] idx;

   always_comb begin
      nib[0] = width[15:12];
      nib[1] = width[11:8];
      nib[2] = width[7:4];
      nib[3] = width[3:0];
      nib[4] = height[15:12];
      nib[5] = height[11:8];
      nib[6] = height[7:4];
      nib[7] = height[3:0];
      nib[8] = interlaced;
      data   = '0;
      idx    = '0;
      for (int j = 0; j < COLOR_PLANES; j++) begin
         idx = {4'd0, beat} * 8'(COLOR_PLANES) + 8'(j);
         // Symbols past the ninth nibble stay zero.
         if (idx < 8'd9) data[j*COLOR_BITS +: 4] = nib[idx[3:0]];
      end
   end
endmodule

// File: rtl/brightness_control_encode.sv
// Re-encodes a bare pixel stream as control packet + video packet per frame.
// BRIGHTNESS_CONTROL_ENCODE_CTRL_PKT_EN enables the control packet; otherwise only the video type beat is added.
module brightness_control_encode
   import brightness_control_pkg::*;
#(
   parameter int DATA_WIDTH   = 24,
   parameter int COLOR_BITS   = 8,
   parameter int COLOR_PLANES = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [15:0]                 im_width,
   input  logic [15:0]                 im_height,
   input  logic [3:0]                  im_interlaced,
   brightness_control_encode_if.slave  din,
   brightness_control_encode_if.master dout
);
   localparam int HDR_BEATS = int'(hdr_beats(COLOR_PLANES));

   state_t state;

`ifdef BRIGHTNESS_CONTROL_ENCODE_CTRL_PKT_EN
   logic [15:0]           lat_width;
   logic [15:0]           lat_height;
   logic [3:0]            lat_interlaced;
   logic [3:0]            cnt;
   logic [DATA_WIDTH-1:0] hdr_data;

   brightness_control_hdr_pack #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COLOR_BITS  (COLOR_BITS),
      .COLOR_PLANES(COLOR_PLANES)
   ) u_hdr_pack (
      .width      (lat_width),
      .height     (lat_height),
      .interlaced (lat_interlaced),
      .beat       (cnt),
      .data       (hdr_data)
   );
`else
   logic unused_im;
   assign unused_im = ^{im_width, im_height, im_interlaced};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
`ifdef BRIGHTNESS_CONTROL_ENCODE_CTRL_PKT_EN
         cnt            <= '0;
         lat_width      <= '0;
         lat_height     <= '0;
         lat_interlaced <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (din.valid && din.startofpacket) begin
`ifdef BRIGHTNESS_CONTROL_ENCODE_CTRL_PKT_EN
               lat_width      <= im_width;
               lat_height     <= im_height;
               lat_interlaced <= im_interlaced;
               state          <= ST_CTYPE;
`else
               state <= ST_VTYPE;
`endif
            end
`ifdef BRIGHTNESS_CONTROL_ENCODE_CTRL_PKT_EN
            ST_CTYPE: if (dout.ready) begin
               cnt   <= '0;
               state <= ST_CHEAD;
            end
            ST_CHEAD: if (dout.ready) begin
               if (cnt == 4'(HDR_BEATS - 1)) begin
                  cnt   <= '0;
                  state <= ST_VTYPE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
`endif
            ST_VTYPE: if (dout.ready) state <= ST_DATA;
            ST_DATA:  if (din.valid && dout.ready && din.endofpacket) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Generated beats depend only on registered state, so they hold under backpressure.
   always_comb begin
      dout.valid         = 1'b0;
      dout.data          = '0;
      dout.startofpacket = 1'b0;
      dout.endofpacket   = 1'b0;
      din.ready          = 1'b0;
      case (state)
         ST_IDLE: din.ready = ~din.startofpacket;
`ifdef BRIGHTNESS_CONTROL_ENCODE_CTRL_PKT_EN
         ST_CTYPE: begin
            dout.valid         = 1'b1;
            dout.data[3:0]     = TYPE_CTRL;
            dout.startofpacket = 1'b1;
         end
         ST_CHEAD: begin
            dout.valid       = 1'b1;
            dout.data        = hdr_data;
            dout.endofpacket = (cnt == 4'(HDR_BEATS - 1));
         end
`endif
         ST_VTYPE: begin
            dout.valid         = 1'b1;
            dout.data[3:0]     = TYPE_VIDEO;
            dout.startofpacket = 1'b1;
         end
         ST_DATA: begin
            dout.valid       = din.valid;
            dout.data        = din.data;
            dout.endofpacket = din.endofpacket;
            din.ready        = dout.ready;
         end
         default: ;
      endcase
   end
endmodule
